// File: rtl/time_mode_ctrl.sv
// -----------------------------------------------------------------------------
// time_mode_ctrl
//   Mode/channel controller for the watch/stopwatch display path. Picks one of
//   NUM_CH packed time sources through next/prev button pulses or a direct
//   (UART) select command, and registers the selected time word towards the
//   7-segment controller. It also drives a one-hot mode LED, steers channel
//   reset requests to the selected channel only, and falls back to channel 0
//   (home/watch) after an idle timeout.
//
//   Optional feature macro: MODE_BLINK_EN
//     defined   : the LED bit of the selected channel blinks at 2 Hz while
//                 that channel is running (phase restarts ON on mode change)
//     undefined : LED is a steady one-hot of o_sel, no blink logic built
//
// Parameters
//   NUM_CH    number of time channels (2..16), channel 0 is home
//   TIME_W    width of one packed time word {hour,min,sec,msec}
//   CLK_HZ    clock frequency in Hz
//   IDLE_SEC  idle seconds before auto-return to channel 0 (0 = disabled)
//
// Ports
//   clk             system clock
//   rst             synchronous reset, active-low
//   i_mode_next     pulse: select next channel (wraps)
//   i_mode_prev     pulse: select previous channel (wraps)
//   i_direct_valid  pulse: load i_direct_sel
//   i_direct_sel    direct channel index, out-of-range values ignored
//   i_rst_req       pulse: reset the currently selected channel
//   i_activity      any other user activity, restarts the idle timer
//   i_ch_running    per-channel running flag
//   i_time_bus      channel k at [k*TIME_W +: TIME_W]
//   o_sel           selected channel index
//   o_led           one-hot mode LED
//   o_time          registered time of the selected channel
//   o_ch_rst        one-cycle one-hot reset pulse to a channel
//   o_mode_changed  one-cycle pulse whenever o_sel changes
// -----------------------------------------------------------------------------
module time_mode_ctrl #(
  parameter  int NUM_CH   = 4,
  parameter  int TIME_W   = 24,
  parameter  int CLK_HZ   = 100_000_000,
  parameter  int IDLE_SEC = 10,
  localparam int SEL_W    = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_mode_next,
  input  logic                     i_mode_prev,
  input  logic                     i_direct_valid,
  input  logic [SEL_W-1:0]         i_direct_sel,
  input  logic                     i_rst_req,
  input  logic                     i_activity,
  input  logic [NUM_CH-1:0]        i_ch_running,
  input  logic [NUM_CH*TIME_W-1:0] i_time_bus,
  output logic [SEL_W-1:0]         o_sel,
  output logic [NUM_CH-1:0]        o_led,
  output logic [TIME_W-1:0]        o_time,
  output logic [NUM_CH-1:0]        o_ch_rst,
  output logic                     o_mode_changed
);

  localparam int IDLE_CYC = IDLE_SEC * CLK_HZ;

  logic [SEL_W-1:0]  r_sel;
  logic [NUM_CH-1:0] r_led;
  logic [TIME_W-1:0] r_time;
  logic [NUM_CH-1:0] r_ch_rst;
  logic              r_mode_changed;

  logic [SEL_W-1:0]  w_sel_nxt;
  logic              w_chg;
  logic              w_return;
  logic              w_clear;

  // Any user interaction restarts the idle timer.
  assign w_clear = i_mode_next | i_mode_prev | i_direct_valid | i_rst_req | i_activity;

  // ---------------------------------------------------------------------------
  // Next-selection logic. Priority: direct command > auto-return > next/prev.
  // A direct command owns the cycle even when it is rejected, so it never
  // lets a simultaneous next/prev slip through.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    w_sel_nxt = r_sel;
    if (i_direct_valid) begin
      if (int'(i_direct_sel) < NUM_CH) begin
        w_sel_nxt = i_direct_sel;
      end
    end else if (w_return) begin
      w_sel_nxt = '0;
    end else if (i_mode_next && !i_mode_prev) begin
      w_sel_nxt = (r_sel == SEL_W'(NUM_CH - 1)) ? '0 : r_sel + 1'b1;
    end else if (i_mode_prev && !i_mode_next) begin
      w_sel_nxt = (r_sel == '0) ? SEL_W'(NUM_CH - 1) : r_sel - 1'b1;
    end
  end

  assign w_chg = (w_sel_nxt != r_sel);

  // ---------------------------------------------------------------------------
  // Main registers. The channel reset uses r_sel, i.e. the channel selected
  // before any change taking effect at the same edge. o_time is sampled from
  // the current r_sel, so a new channel's time appears one cycle after o_sel.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (!rst) begin
      r_sel          <= '0;
      r_led          <= NUM_CH'(1);
      r_time         <= '0;
      r_ch_rst       <= '0;
      r_mode_changed <= 1'b0;
    end else begin
      r_sel          <= w_sel_nxt;
      r_led          <= NUM_CH'(1) << w_sel_nxt;
      r_time         <= i_time_bus[int'(r_sel) * TIME_W +: TIME_W];
      r_ch_rst       <= i_rst_req ? (NUM_CH'(1) << r_sel) : '0;
      r_mode_changed <= w_chg;
    end
  end

  // ---------------------------------------------------------------------------
  // Idle timer and auto-return. The counter saturates at IDLE_CYC; while the
  // selected channel is running it stays saturated, so the return fires on the
  // first cycle the channel stops.
  // ---------------------------------------------------------------------------
  generate
    if (IDLE_CYC > 0) begin : g_idle
      localparam int CNT_W = $clog2(IDLE_CYC + 1);

      logic [CNT_W-1:0] r_idle_cnt;
      logic             w_sat;

      assign w_sat    = (r_idle_cnt == CNT_W'(IDLE_CYC));
      assign w_return = w_sat && (r_sel != '0) && !i_ch_running[r_sel];

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_idle_cnt <= '0;
        end else if (w_clear || w_return) begin
          r_idle_cnt <= '0;
        end else if (!w_sat) begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
      end
    end else begin : g_no_idle
      logic w_unused_clear;
      assign w_unused_clear = w_clear;
      assign w_return       = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Mode LED.
  // ---------------------------------------------------------------------------
`ifdef MODE_BLINK_EN
  localparam int BLINK_HALF = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
  localparam int BLK_W      = $clog2(BLINK_HALF + 1);

  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_on;

  // Half-period counter: the lit bit toggles every CLK_HZ/4 cycles while the
  // selected channel runs, and restarts ON whenever the mode changes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_chg || !i_ch_running[r_sel]) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (r_blink_cnt == BLK_W'(BLINK_HALF - 1)) begin
      r_blink_cnt <= '0;
      r_blink_on  <= ~r_blink_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign o_led = r_led & {NUM_CH{r_blink_on}};
`else
  assign o_led = r_led;
`endif

  assign o_sel          = r_sel;
  assign o_time         = r_time;
  assign o_ch_rst       = r_ch_rst;
  assign o_mode_changed = r_mode_changed;

endmodule

// File: tb/tb_time_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_mode_ctrl
//   Directed bench for time_mode_ctrl. Stimulus pushes expected mode changes
//   and channel-reset pulses (value plus the cycle they must appear in) into
//   queues; monitors pop and compare whenever the DUT pulses o_mode_changed or
//   o_ch_rst. A second instance with NUM_CH=3 and auto-return disabled covers
//   the out-of-range direct select.
// -----------------------------------------------------------------------------
module tb_time_mode_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT: NUM_CH=4, CLK_HZ=1000, IDLE_SEC=2 -> 2000 idle cycles
  logic        rst;
  logic        mode_next, mode_prev, direct_valid, rst_req, activity;
  logic [1:0]  direct_sel;
  logic [3:0]  running;
  logic [95:0] time_bus;
  logic [1:0]  sel;
  logic [3:0]  led;
  logic [23:0] tim;
  logic [3:0]  ch_rst;
  logic        mode_chg;

  time_mode_ctrl #(.NUM_CH(4), .TIME_W(24), .CLK_HZ(1000), .IDLE_SEC(2)) dut (
    .clk(clk), .rst(rst),
    .i_mode_next(mode_next), .i_mode_prev(mode_prev),
    .i_direct_valid(direct_valid), .i_direct_sel(direct_sel),
    .i_rst_req(rst_req), .i_activity(activity),
    .i_ch_running(running), .i_time_bus(time_bus),
    .o_sel(sel), .o_led(led), .o_time(tim),
    .o_ch_rst(ch_rst), .o_mode_changed(mode_chg)
  );

  // Second DUT: NUM_CH=3, idle return disabled
  logic        d3_next, d3_dv;
  logic [1:0]  d3_dsel;
  logic [1:0]  d3_sel;
  logic [2:0]  d3_led;
  logic [23:0] d3_time;
  logic [2:0]  d3_chrst;
  logic        d3_mchg;

  time_mode_ctrl #(.NUM_CH(3), .TIME_W(24), .CLK_HZ(1000), .IDLE_SEC(0)) dut3 (
    .clk(clk), .rst(rst),
    .i_mode_next(d3_next), .i_mode_prev(1'b0),
    .i_direct_valid(d3_dv), .i_direct_sel(d3_dsel),
    .i_rst_req(1'b0), .i_activity(1'b0),
    .i_ch_running(3'b000), .i_time_bus(time_bus[71:0]),
    .o_sel(d3_sel), .o_led(d3_led), .o_time(d3_time),
    .o_ch_rst(d3_chrst), .o_mode_changed(d3_mchg)
  );

  typedef struct {
    logic [3:0] val;
    int         due;
  } exp_t;

  exp_t mode_q[$];
  exp_t rst_q[$];
  exp_t mode3_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int last_act;
  int d_blink;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Monitors (sample on the falling edge, away from the active edge)
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (mode_chg) begin
      if (mode_q.size() == 0) begin
        check("mode_chg_unexpected", 32'd1, 32'd0);
      end else begin
        e = mode_q.pop_front();
        check("mode_sel", 32'(sel), 32'(e.val));
        check("mode_led", 32'(led), 32'(4'b0001 << e.val));
        check("mode_cycle", cyc, e.due);
      end
    end
    if (ch_rst != 4'b0000) begin
      if (rst_q.size() == 0) begin
        check("ch_rst_unexpected", 32'(ch_rst), 32'd0);
      end else begin
        e = rst_q.pop_front();
        check("ch_rst_val", 32'(ch_rst), 32'(e.val));
        check("ch_rst_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (d3_mchg) begin
      if (mode3_q.size() == 0) begin
        check("d3_mode_chg_unexpected", 32'd1, 32'd0);
      end else begin
        e = mode3_q.pop_front();
        check("d3_mode_sel", 32'(d3_sel), 32'(e.val));
        check("d3_mode_led", 32'(d3_led), 32'(3'b001 << e.val));
        check("d3_mode_cycle", cyc, e.due);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle pulse on the main DUT's request inputs.
  task automatic pulse(input logic n, input logic p, input logic v,
                       input logic r, input logic a, input logic [1:0] s);
    mode_next = n; mode_prev = p; direct_valid = v;
    rst_req = r; activity = a; direct_sel = s;
    tick();
    mode_next = 1'b0; mode_prev = 1'b0; direct_valid = 1'b0;
    rst_req = 1'b0; activity = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b0;
    mode_next = 1'b0; mode_prev = 1'b0; direct_valid = 1'b0;
    rst_req = 1'b0; activity = 1'b0; direct_sel = 2'd0;
    running = 4'b0000;
    d3_next = 1'b0; d3_dv = 1'b0; d3_dsel = 2'd0;
    time_bus = {24'h333333, 24'h222222, 24'h111111, 24'h0A1B2C};

    // Reset held for three cycles
    tick(3);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_led", 32'(led), 32'h1);
    check("rst_time", 32'(tim), 32'd0);
    check("rst_ch_rst", 32'(ch_rst), 32'd0);
    check("rst_mode_chg", 32'(mode_chg), 32'd0);
    check("rst_d3_sel", 32'(d3_sel), 32'd0);
    rst = 1'b1;
    tick();
    check("time_ch0_after_rst", 32'(tim), 32'h0A1B2C);

    // Next wraps 3 -> 0, prev wraps 0 -> 3, next+prev is a no-op
    for (int i = 1; i <= 4; i++) begin
      mode_q.push_back('{val: 4'(i % 4), due: cyc + 1});
      pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    end
    mode_q.push_back('{val: 4'd3, due: cyc + 1});
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(2);
    check("next_prev_noop", 32'(sel), 32'd3);

    // Channel reset goes to the channel selected before a same-cycle change
    mode_q.push_back('{val: 4'd1, due: cyc + 1});
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    rst_q.push_back('{val: 4'b0010, due: cyc + 1});
    mode_q.push_back('{val: 4'd2, due: cyc + 1});
    pulse(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    check("ch_rst_one_cycle", 32'(ch_rst), 32'd0);
    check("time_ch2", 32'(tim), 32'h222222);
    time_bus[2*24 +: 24] = 24'h2A2A2A;
    tick();
    check("time_tracks_bus", 32'(tim), 32'h2A2A2A);

    // Direct select of the current channel: no change, no pulse
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    tick(2);
    check("direct_same_sel", 32'(sel), 32'd2);

    // NUM_CH=3: direct beats next; out-of-range direct is ignored
    mode3_q.push_back('{val: 4'd2, due: cyc + 1});
    d3_dv = 1'b1; d3_dsel = 2'd2; d3_next = 1'b1;
    tick();
    d3_dv = 1'b0; d3_next = 1'b0;
    d3_dv = 1'b1; d3_dsel = 2'd3;
    tick();
    d3_dv = 1'b0;
    tick(2);
    check("d3_out_of_range_ignored", 32'(d3_sel), 32'd2);

    // Idle auto-return: counter cleared at last_act, saturates 2000 edges later,
    // return lands on the following edge
    last_act = cyc + 1;
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    mode_q.push_back('{val: 4'd0, due: last_act + 2001});
    tick(2100);
    check("idle_return", 32'(sel), 32'd0);

    // Running channel holds off the return until it stops
    running = 4'b0100;
    mode_q.push_back('{val: 4'd2, due: cyc + 1});
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    tick(2100);
    check("idle_hold_running", 32'(sel), 32'd2);
    running = 4'b0000;
    mode_q.push_back('{val: 4'd0, due: cyc + 1});
    tick(2);
    check("idle_return_after_stop", 32'(sel), 32'd0);

    // Activity restarts the idle timer
    mode_q.push_back('{val: 4'd1, due: cyc + 1});
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    tick(1500);
    last_act = cyc + 1;
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    mode_q.push_back('{val: 4'd0, due: last_act + 2001});
    tick(2100);
    check("idle_restart_by_activity", 32'(sel), 32'd0);

    // Mode LED while the selected channel runs
    running = 4'b0010;
    d_blink = cyc + 1;
    mode_q.push_back('{val: 4'd1, due: d_blink});
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    tick(d_blink + 100 - cyc);
    check("led_t100", 32'(led), 32'b0010);
    tick(d_blink + 300 - cyc);
`ifdef MODE_BLINK_EN
    check("led_t300_blink_off", 32'(led), 32'b0000);
`else
    check("led_t300_steady", 32'(led), 32'b0010);
`endif
    tick(d_blink + 550 - cyc);
    check("led_t550", 32'(led), 32'b0010);

    tick(3);
    check("mode_q_drained", mode_q.size(), 32'd0);
    check("rst_q_drained", rst_q.size(), 32'd0);
    check("mode3_q_drained", mode3_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
